// File: rtl/count_enable_gen.sv
// Run/stop enable generator for the 4-bit JK counter: synchronises and debounces two
// push-buttons, then issues one-cycle enable ticks from a prescaler (RUN) or per step press (STOP).

module count_enable_gen_btn #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic          db_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any return of s2 to the accepted level restarts the stability window.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign press_o = db_q & ~db_prev_q;
endmodule

module count_enable_gen #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_step,
  output logic en,
  output logic J,
  output logic K,
  output logic running
);
  localparam int unsigned   PW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          en_q, en_d;
  logic          running_q, running_d;
  logic          run_press, step_press;

  count_enable_gen_btn #(.DB_CYCLES(DB_CYCLES)) u_run_btn (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_run),
    .press_o (run_press)
  );

  count_enable_gen_btn #(.DB_CYCLES(DB_CYCLES)) u_step_btn (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_step),
    .press_o (step_press)
  );

  // A run toggle always takes priority: it discards a coincident step and a due tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    en_d    = 1'b0;
    unique case (state_q)
      ST_STOP: begin
        if (run_press) begin
          state_d = ST_RUN;
          presc_d = '0;
        end else if (step_press) begin
          en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_press) begin
          state_d = ST_STOP;
          presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          en_d    = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = ST_STOP;
        presc_d = '0;
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      en_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      en_q      <= en_d;
      running_q <= running_d;
    end
  end

  assign en      = en_q;
  assign J       = en_q;
  assign K       = en_q;
  assign running = running_q;
endmodule

// File: tb/tb_count_enable_gen.sv
// Directed bench for count_enable_gen with DIV=4, DB_CYCLES=3; outputs sampled 1 ns after each rising edge.

module tb_count_enable_gen;
  localparam int unsigned DIV = 4;
  localparam int unsigned DB  = 3;

  logic clk = 1'b0;
  logic rst, btn_run, btn_step;
  logic en, J, K, running;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ticks = 0;
  int t_run = 0;

  count_enable_gen #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .en       (en),
    .J        (J),
    .K        (K),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic step_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (en === 1'b1) ticks++;
  endtask

  task automatic apply_reset();
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0;
    step_cycle(); step_cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step_cycle();
    ticks = 0;
  endtask

  task automatic test_reset();
    logic exp_run, exp_en;
    rst = 1'b1; btn_run = 1'b1; btn_step = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step_cycle();
      tests++;
      if ({en, J, K, running} !== 4'b0000) begin
        fails++; $display("FAIL reset_hold: got %b expected 0000", {en, J, K, running});
      end
    end
    rst = 1'b0;
    // Both buttons held through reset: run wins, step discarded, first tick 4 edges later.
    for (int i = 1; i <= 10; i++) begin
      step_cycle();
      exp_run = (i >= 6);
      exp_en  = (i == 10);
      if (i == 6) begin btn_run = 1'b0; btn_step = 1'b0; end
      tests++;
      if (running !== exp_run) begin
        fails++; $display("FAIL reset_release_running[%0d]: got %b expected %b", i, running, exp_run);
      end
      tests++;
      if ({en, J, K} !== {3{exp_en}}) begin
        fails++; $display("FAIL reset_release_en[%0d]: got %b expected %b", i, {en, J, K}, {3{exp_en}});
      end
    end
  endtask

  task automatic test_run();
    logic exp_en;
    apply_reset();
    btn_run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step_cycle();
      tests++;
      if (running !== (i == 6) || en !== 1'b0) begin
        fails++; $display("FAIL run_entry[%0d]: got running=%b en=%b expected running=%b en=0", i, running, en, (i == 6));
      end
    end
    t_run = cyc;
    for (int k = 1; k <= 32; k++) begin
      step_cycle();
      if (k == 14) btn_run = 1'b0;
      exp_en = ((k % 4) == 0);
      tests++;
      if ({en, J, K} !== {3{exp_en}} || running !== 1'b1) begin
        fails++; $display("FAIL run_tick[%0d]: got en/J/K=%b running=%b expected %b running=1", k, {en, J, K}, running, {3{exp_en}});
      end
    end
    tests++;
    if (ticks !== 8) begin
      fails++; $display("FAIL run_count: got %0d expected 8", ticks);
    end
  endtask

  task automatic test_stop_collision();
    logic exp_run, exp_en;
    int   base;
    // Advance from t_run+32 to t_run+34 so the stop press lands on the t_run+40 tick edge.
    for (int i = 0; i < 2; i++) begin
      step_cycle();
      tests++;
      if (en !== 1'b0) begin
        fails++; $display("FAIL collision_pre[%0d]: got %b expected 0", i, en);
      end
    end
    base = ticks;
    btn_run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step_cycle();
      if (i == 10) btn_run = 1'b0;
      exp_run = (i < 6);
      exp_en  = exp_run && (((cyc - t_run) % 4) == 0);
      tests++;
      if (running !== exp_run || en !== exp_en) begin
        fails++; $display("FAIL collision[%0d]: got running=%b en=%b expected running=%b en=%b", i, running, en, exp_run, exp_en);
      end
    end
    tests++;
    if (ticks !== base + 1) begin
      fails++; $display("FAIL collision_count: got %0d expected %0d", ticks, base + 1);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      btn_step = pat[i];
      step_cycle();
      tests++;
      if (en !== 1'b0) begin
        fails++; $display("FAIL bounce_toggle[%0d]: got %b expected 0", i, en);
      end
    end
    btn_step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step_cycle();
      tests++;
      if (en !== 1'b0 || running !== 1'b0) begin
        fails++; $display("FAIL bounce_quiet[%0d]: got en=%b running=%b expected 0 0", i, en, running);
      end
    end
    btn_step = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step_cycle();
      if (i == 10) btn_step = 1'b0;
      tests++;
      if ({en, J, K} !== {3{i == 6}} || running !== 1'b0) begin
        fails++; $display("FAIL step_tick[%0d]: got en/J/K=%b running=%b expected %b running=0", i, {en, J, K}, running, {3{i == 6}});
      end
    end
  endtask

  task automatic test_simultaneous();
    logic exp_run, exp_en;
    int   p;
    p = cyc;
    btn_run = 1'b1; btn_step = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step_cycle();
      if (i == 10) begin btn_run = 1'b0; btn_step = 1'b0; end
      exp_run = (i >= 6);
      exp_en  = exp_run && (i > 6) && (((i - 6) % 4) == 0);
      tests++;
      if (running !== exp_run || en !== exp_en) begin
        fails++; $display("FAIL simul_stop[%0d]: got running=%b en=%b expected running=%b en=%b", i, running, en, exp_run, exp_en);
      end
    end
    t_run = p + 6;
    step_cycle();
    tests++;
    if (en !== 1'b0) begin
      fails++; $display("FAIL simul_gap: got %b expected 0", en);
    end
    btn_run = 1'b1; btn_step = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step_cycle();
      if (i == 10) begin btn_run = 1'b0; btn_step = 1'b0; end
      exp_run = (i < 6);
      exp_en  = exp_run && (((cyc - t_run) % 4) == 0);
      tests++;
      if (running !== exp_run || en !== exp_en) begin
        fails++; $display("FAIL simul_run[%0d]: got running=%b en=%b expected running=%b en=%b", i, running, en, exp_run, exp_en);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    btn_run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step_cycle();
      if (i == 6) btn_run = 1'b0;
      tests++;
      if (running !== (i >= 6) || en !== 1'b0) begin
        fails++; $display("FAIL midrun_entry[%0d]: got running=%b en=%b expected running=%b en=0", i, running, en, (i >= 6));
      end
    end
    rst = 1'b1;
    step_cycle();
    tests++;
    if ({en, J, K, running} !== 4'b0000) begin
      fails++; $display("FAIL midrun_reset: got %b expected 0000", {en, J, K, running});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_cycle();
      tests++;
      if ({en, J, K, running} !== 4'b0000) begin
        fails++; $display("FAIL midrun_idle[%0d]: got %b expected 0000", i, {en, J, K, running});
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stop_collision();
    test_bounce();
    test_simultaneous();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
